csr_uart: RTL and testbench
===========================

// Module: csr_uart
// PURPOSE
//   UART peripheral on the core's CSR bus; consumes the character writes the pipeline issues to CSR 0xBC0.
//   Buffers bytes in a TX FIFO and serialises them 8N1 on pin tx. An optional receiver deframes rx into a holding register.
//   Status is returned through the same CSR.
//   rdata/valid are OR-combined with the other CSR peripherals. Outside BASE_ADDR, both are zero.
// PARAMETERS
//   BASE_ADDR  12'hBC0  CSR address decoded by this block
//   CLK_KHZ    1000     core clock frequency in kHz
//   BAUD       115200   line rate; DIV = (CLK_KHZ*1000)/BAUD, truncated; elaboration error if DIV<2
//   FIFO_LOG2  2        TX FIFO depth = 2**FIFO_LOG2 entries of 8 bit
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   reset, synchronous, active-high
//   read           in   1   CSR read strobe, refers to address latched in the previous cycle
//   modify         in   3   CSR op: 0 none, 1 write, 2 set bits, 3 clear bits, others none
//   wdata          in   32  CSR write data
//   addr           in   12  CSR address; registered every cycle into q_Addr
//   rdata          out  32  read data, zero when valid=0
//   valid          out  1   this block claims the access
//   tx             out  1   serial output, idle high
//   rx             in   1   serial input (present only with CSR_UART_RX_EN)
//   AVOID_WARNING  out  1   tied 0
// BEHAVIOUR
//   Reset: tx=1, rdata=0, valid=0, FIFO empty, TX FSM=IDLE, all sticky flags 0; applies in any state, a frame in flight is aborted (tx=1 next cycle).
//   Decode: hit = (q_Addr==BASE_ADDR). read&hit in cycle N -> valid=1, rdata=STATUS in N+1 (registered, 1-cycle latency).
//   STATUS: [7:0] rx byte, [8] rx_valid, [9] tx_full, [10] tx_overflow, [11] rx_frame_err, [12] rx_overrun, [13] tx_busy (FIFO non-empty or FSM!=IDLE); rest 0.
//   modify==1 & hit: push wdata[7:0]. If full, the byte is dropped and tx_overflow is set.
//   modify==3 & hit: clear sticky bits selected by wdata[12:10]. modify==2 ignored, no push.
//   A pop and a push in the same cycle when full: the pop frees the slot and the push is accepted, no overflow.
//   FIFO pointers are FIFO_LOG2+1 bit and wrap naturally. full = MSBs differ and LSBs equal. empty = pointers equal.
//   TX FSM: IDLE -(FIFO non-empty: pop into shift reg)-> START(tx=0) -> DATA(8 bits, LSB first) -> STOP(tx=1) -> IDLE.
//     Each state bit lasts exactly DIV clocks, from a down-counter reloaded at every bit boundary.
//     STOP->IDLE->START back-to-back with no extra idle bit: a frame is exactly 10*DIV clocks.
//   read&hit with rx_valid=1 consumes the byte: rx_valid=0 in the cycle after rdata is returned.
//   modify==1 with hit in the same cycle as read: both take effect.
// CONFIGURATION
//   CSR_UART_RX_EN defined:
//     rx goes through a 2-FF synchroniser, and a falling edge in RX_IDLE starts a frame.
//     Sampling at mid-bit (DIV/2, then every DIV). A start bit sampled high returns to idle silently.
//     stop=0 sets rx_frame_err and discards the byte.
//     A good byte while rx_valid=1 sets rx_overrun and keeps the old byte.
//   Not defined: no rx port, no receiver logic; STATUS[8], [11], [12] and [7:0] read 0.
// STRUCTURE
//   Shared package/header csr_uart_defs: CSR op codes (NONE/WRITE/SET/CLEAR), STATUS bit indices, TX/RX state encodings.
//   Sub-module uart_sync_fifo (WIDTH=8, LOG2): push/pop/full/empty, registered read head, synchronous active-high reset.
//   Top holds the CSR decode, status register, TX FSM/baud counter and the optional RX FSM.
// TESTING
//   CLK_KHZ=1000, BAUD=250000 (DIV=4) unless stated.
//   1 Write 0x55 -> tx low for 4 clk, then 1,0,1,0,1,0,1,0 each 4 clk, then high 4 clk; frame 40 clk; tx_busy=0 after.
//   2 Write 0x41,0x42,0x43,0x44,0x45 back-to-back, FIFO_LOG2=2 -> first popped at once, next four fill FIFO.
//     Exactly 5 frames, no overflow; a 6th write while full -> STATUS[10]=1; clear with wdata=0x400 -> 0.
//   3 Read STATUS at addr 0xBC0 -> valid=1 exactly one cycle after read. Read at addr 0xBC1 -> valid=0, rdata=0.
//   4 Assert rst for 1 clk in the middle of DATA bit 3 -> tx=1 next cycle, FIFO empty, STATUS=0, no further frame.
//   5 (RX_EN) Drive 0xA5 8N1 at DIV=4 -> STATUS[8:0]=0x1A5.
//     Read it -> rx_valid clears. A second byte before the read -> STATUS[12]=1, byte stays 0xA5.
//   6 (RX_EN) Drive frame with stop=0 -> STATUS[11]=1, rx_valid=0.

Source files
------------

// File: rtl/csr_uart_defs.sv
// Shared CSR op codes, STATUS bit positions and TX/RX state encodings for csr_uart.
package csr_uart_defs;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;

  localparam int ST_RX_VALID = 8;
  localparam int ST_TX_FULL  = 9;
  localparam int ST_TX_OVF   = 10;
  localparam int ST_RX_FERR  = 11;
  localparam int ST_RX_OVR   = 12;
  localparam int ST_TX_BUSY  = 13;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, 2**LOG2 entries; head visible on dout while non-empty, pop takes effect at the edge.
// A push when full is accepted only if a pop frees the slot in the same cycle; pop on empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [LOG2:0]      wp, rp;
  logic [WIDTH-1:0]   mem [2**LOG2];
  logic               do_pop, do_push;

  assign empty   = (wp == rp);
  assign full    = (wp[LOG2] != rp[LOG2]) && (wp[LOG2-1:0] == rp[LOG2-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: it is only observed through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/csr_uart.sv
// CSR-mapped 8N1 UART: TX FIFO + serialiser, status read with 1-cycle latency, writes to a full FIFO are dropped.
// Receiver and its status bits exist only when CSR_UART_RX_EN is defined.
module csr_uart
  import csr_uart_defs::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'hBC0,
  parameter int          CLK_KHZ   = 1000,
  parameter int          BAUD      = 115200,
  parameter int          FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        tx,
`ifdef CSR_UART_RX_EN
  input  logic        rx,
`endif
  output logic        AVOID_WARNING
);

  localparam int DIV = (CLK_KHZ * 1000) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("csr_uart: baud divider must be at least 2");
  end

  logic [11:0] q_Addr;
  logic        hit, csr_rd, csr_wr, csr_clr;
  logic        fifo_pop, fifo_full, fifo_empty, tx_busy;
  logic [7:0]  fifo_dat;
  logic [31:0] status;
  logic        tx_ovf;
  logic        unused_wdata;

  assign hit           = (q_Addr == BASE_ADDR);
  assign csr_rd        = read && hit;
  assign csr_wr        = hit && (modify == OP_WRITE);
  assign csr_clr       = hit && (modify == OP_CLEAR);
  assign AVOID_WARNING = 1'b0;
  assign unused_wdata  = ^wdata;

  uart_sync_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (csr_wr),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  tx_state_e       tx_state, tx_state_nx;
  logic [CW-1:0]   tx_cnt, tx_cnt_nx;
  logic [7:0]      tx_sh, tx_sh_nx;
  logic [2:0]      tx_bit, tx_bit_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_sh    <= tx_sh_nx;
      tx_bit   <= tx_bit_nx;
    end
  end

  // STOP pops the next byte directly so consecutive frames have no idle gap.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = (tx_cnt == '0) ? RELOAD : tx_cnt - 1'b1;
    tx_sh_nx    = tx_sh;
    tx_bit_nx   = tx_bit;
    fifo_pop    = 1'b0;
    tx          = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = RELOAD;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          tx_sh_nx    = fifo_dat;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_cnt == '0) begin
          tx_state_nx = TX_DATA;
          tx_bit_nx   = '0;
        end
      end
      TX_DATA: begin
        tx = tx_sh[0];
        if (tx_cnt == '0) begin
          tx_sh_nx  = {1'b0, tx_sh[7:1]};
          tx_bit_nx = tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            tx_sh_nx    = fifo_dat;
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  assign tx_busy = !fifo_empty || (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
    end else begin
      if (csr_clr && wdata[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (csr_wr && fifo_full && !fifo_pop) tx_ovf <= 1'b1;
    end
  end

`ifdef CSR_UART_RX_EN
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic            rx_s1, rx_s2, rx_s3;
  rx_state_e       rx_state, rx_state_nx;
  logic [CW-1:0]   rx_cnt, rx_cnt_nx;
  logic [7:0]      rx_sh, rx_sh_nx, rx_byte;
  logic [2:0]      rx_bit, rx_bit_nx;
  logic            rx_good, rx_bad, rx_valid, rx_ferr, rx_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_sh    <= rx_sh_nx;
      rx_bit   <= rx_bit_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = (rx_cnt == '0) ? RELOAD : rx_cnt - 1'b1;
    rx_sh_nx    = rx_sh;
    rx_bit_nx   = rx_bit;
    rx_good     = 1'b0;
    rx_bad      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = HALF;
        if (!rx_s2 && rx_s3) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          rx_bit_nx   = '0;
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_nx  = {rx_s2, rx_sh[7:1]};
          rx_bit_nx = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_good     = rx_s2;
          rx_bad      = !rx_s2;
          rx_state_nx = RX_IDLE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // A byte arriving in the same cycle as the consuming read replaces it, no overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      if (csr_rd) rx_valid <= 1'b0;
      if (csr_clr && wdata[ST_RX_FERR]) rx_ferr <= 1'b0;
      if (csr_clr && wdata[ST_RX_OVR])  rx_ovr  <= 1'b0;
      if (rx_bad) rx_ferr <= 1'b1;
      if (rx_good) begin
        if (rx_valid && !csr_rd) begin
          rx_ovr <= 1'b1;
        end else begin
          rx_byte  <= rx_sh;
          rx_valid <= 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    status             = '0;
    status[ST_TX_FULL] = fifo_full;
    status[ST_TX_OVF]  = tx_ovf;
    status[ST_TX_BUSY] = tx_busy;
`ifdef CSR_UART_RX_EN
    status[7:0]         = rx_byte;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_FERR]  = rx_ferr;
    status[ST_RX_OVR]   = rx_ovr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_Addr <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      q_Addr <= addr;
      valid  <= csr_rd;
      rdata  <= csr_rd ? status : '0;
    end
  end

endmodule

// File: tb/tb_csr_uart.sv
// Directed bench for csr_uart at DIV=4: CSR decode table, TX frame timing, FIFO fill/overflow, reset abort, optional RX.
module tb_csr_uart;
  import csr_uart_defs::*;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        rx = 1'b1;
  logic [2:0]  modify = 3'd0;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid, tx, avoid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_uart #(.BASE_ADDR(12'hBC0), .CLK_KHZ(1000), .BAUD(250000), .FIFO_LOG2(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .read          (read),
    .modify        (modify),
    .wdata         (wdata),
    .addr          (addr),
    .rdata         (rdata),
    .valid         (valid),
    .tx            (tx),
`ifdef CSR_UART_RX_EN
    .rx            (rx),
`endif
    .AVOID_WARNING (avoid)
  );

  typedef struct {
    logic [11:0] a;
    logic        rd;
    logic [2:0]  op;
    logic [31:0] wd;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_mod(input logic [2:0] op, input logic [31:0] d);
    @(negedge clk); addr = 12'hBC0; read = 1'b0; modify = 3'd0;
    @(negedge clk); modify = op; wdata = d;
    @(negedge clk); modify = 3'd0;
  endtask

  // Checks {valid, rdata} of a STATUS read one cycle after the strobe.
  task automatic read_chk(input string nm, input logic [31:0] exp);
    @(negedge clk); addr = 12'hBC0; read = 1'b0; modify = 3'd0;
    @(negedge clk); read = 1'b1;
    @(negedge clk); read = 1'b0;
    chk(nm, {31'b0, valid, rdata}, {31'b0, 1'b1, exp});
  endtask

  // Waits up to maxw cycles for a start bit, then checks every cycle of the 10*DIV frame.
  task automatic check_frame(input logic [7:0] b, input int maxw, input string nm);
    logic [9:0] fr;
    int w, bad;
    fr = {1'b1, b, 1'b0};
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx !== 1'b0 && w < maxw);
    if (tx !== 1'b0) begin
      chk({nm, "_start"}, {63'b0, tx}, 64'd0);
      return;
    end
    bad = -1;
    for (int i = 0; i < 10 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      if (tx !== fr[i / DIV] && bad < 0) bad = i;
    end
    chk({nm, "_first_bad_sample"}, 64'(signed'(bad)), 64'(signed'(-1)));
  endtask

  task automatic idle_chk(input int cycles, input string nm);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk(nm, 64'(lows), 64'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr     rd    op        wdata          v     rdata
    vt[0] = '{12'hBC0, 1'b1, OP_NONE,  32'h0,        1'b1, 32'h0};
    vt[1] = '{12'hBC1, 1'b1, OP_NONE,  32'h0,        1'b0, 32'h0};
    vt[2] = '{12'hBC0, 1'b1, OP_SET,   32'hFF,       1'b1, 32'h0};
    vt[3] = '{12'hBC0, 1'b1, OP_NONE,  32'h0,        1'b1, 32'h0};
    vt[4] = '{12'hBC0, 1'b1, 3'd5,     32'h11,       1'b1, 32'h0};
    vt[5] = '{12'hBC0, 1'b1, OP_NONE,  32'h0,        1'b1, 32'h0};
    vt[6] = '{12'h000, 1'b1, OP_NONE,  32'h0,        1'b0, 32'h0};
    vt[7] = '{12'hBC1, 1'b1, OP_WRITE, 32'h33,       1'b0, 32'h0};
    vt[8] = '{12'hBC0, 1'b1, OP_NONE,  32'h0,        1'b1, 32'h0};
    vt[9] = '{12'hBC0, 1'b0, OP_NONE,  32'h0,        1'b0, 32'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", {63'b0, tx}, 64'd1);
    chk("reset_valid", {63'b0, valid}, 64'd0);
    chk("reset_rdata", {32'b0, rdata}, 64'd0);
    read_chk("reset_status", 32'h0);

    // CSR decode table: SET and undefined ops must not push, misses must return zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); addr = vt[i].a; read = 1'b0; modify = 3'd0;
      @(negedge clk); read = vt[i].rd; modify = vt[i].op; wdata = vt[i].wd;
      @(negedge clk); read = 1'b0; modify = 3'd0;
      chk($sformatf("vec%0d_valid", i), {63'b0, valid}, {63'b0, vt[i].exp_v});
      chk($sformatf("vec%0d_rdata", i), {32'b0, rdata}, {32'b0, vt[i].exp_d});
    end
    idle_chk(20, "no_push_from_table");

    read_chk("pulse_read", 32'h0);
    @(negedge clk);
    chk("valid_one_cycle", {63'b0, valid}, 64'd0);

    // Single frame: exact bit timing and busy drops afterwards.
    do_mod(OP_WRITE, 32'h55);
    check_frame(8'h55, 20, "t1_frame_55");
    read_chk("t1_status_after", 32'h0);

    // Five back-to-back writes fill the FIFO; the sixth overflows.
    fork
      begin
        check_frame(8'h41, 60, "t2_frame_41");
        check_frame(8'h42, 1, "t2_frame_42");
        check_frame(8'h43, 1, "t2_frame_43");
        check_frame(8'h44, 1, "t2_frame_44");
        check_frame(8'h45, 1, "t2_frame_45");
      end
      begin
        @(negedge clk); addr = 12'hBC0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk); modify = OP_WRITE; wdata = 32'h41 + 32'(i);
        end
        @(negedge clk); modify = 3'd0;
        read_chk("t2_full_no_ovf", 32'h2200);
        do_mod(OP_WRITE, 32'h46);
        read_chk("t2_overflow", 32'h2600);
        do_mod(OP_CLEAR, 32'h400);
        read_chk("t2_ovf_cleared", 32'h2200);
      end
    join
    idle_chk(60, "t2_no_sixth_frame");
    read_chk("t2_status_idle", 32'h0);

    // Reset in the middle of DATA bit 3 aborts the frame and empties the FIFO.
    do_mod(OP_WRITE, 32'h00);
    do_mod(OP_WRITE, 32'hFF);
    begin
      int w;
      w = 0;
      while (tx !== 1'b0 && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    chk("t4_start_seen", {63'b0, tx}, 64'd0);
    repeat (4 * DIV + 1) @(negedge clk);
    chk("t4_in_bit3", {63'b0, tx}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_tx_after_rst", {63'b0, tx}, 64'd1);
    read_chk("t4_status_after_rst", 32'h0);
    idle_chk(100, "t4_no_frame_after_rst");

`ifdef CSR_UART_RX_EN
    send_rx(8'hA5, 1'b1);
    read_chk("t5_rx_byte", 32'h1A5);
    read_chk("t5_rx_consumed", 32'h0A5);
    send_rx(8'hA5, 1'b1);
    send_rx(8'h5A, 1'b1);
    read_chk("t5_overrun", 32'h11A5);
    read_chk("t5_overrun_consumed", 32'h10A5);
    do_mod(OP_CLEAR, 32'h1000);
    read_chk("t5_overrun_cleared", 32'h00A5);
    send_rx(8'h0F, 1'b0);
    read_chk("t6_frame_err", 32'h08A5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
